// File: rtl/spi_aes_frame_port.sv
// Serial load/send frame port in front of an AES core (AES-128/192/256).
// Checks load and send frame lengths and flags malformed frames.
module spi_aes_frame_port #(
    parameter int NK        = 4,
    parameter bit LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             miso,
    input  logic [127:0]     parallelprocessedin,
    input  logic             finished,
    output logic [127:0]     parallelmessageout,
    output logic [NK*32-1:0] parallelkeyout,
    output logic             mosi,
    output logic             ready,
    output logic             frame_err,
    output logic             busy
);

    localparam int KW = NK * 32;
    localparam int L  = 128 + KW;
    localparam logic [8:0] L_C   = 9'(L);
    localparam logic [8:0] SAT_C = 9'(L + 1);
    localparam logic [8:0] S_C   = 9'd128;

    typedef enum logic [1:0] {
        LOAD,
        WAIT_CORE,
        SEND
    } state_t;

    state_t         state_q, state_d;
    logic           cs_q;
    logic [8:0]     cnt_q, cnt_d, cnt_inc;
    logic [L-1:0]   stage_q, stage_d;
    logic [127:0]   msg_q, msg_d;
    logic [KW-1:0]  key_q, key_d;
    logic [127:0]   snd_q, snd_d;
    logic           mosi_q, mosi_d;
    logic           ready_q, ready_d;
    logic           ferr_q, ferr_d;
    logic           fend;
    logic [6:0]     bidx;
    logic [127:0]   stage_msg;
    logic [KW-1:0]  stage_key;

    // LSB-first fills from the top, so the first bit lands at index 0
    always_comb begin
        if (LSB_FIRST) begin
            stage_msg = stage_q[127:0];
            stage_key = stage_q[L-1:128];
            bidx      = cnt_q[6:0];
        end else begin
            stage_msg = stage_q[L-1:KW];
            stage_key = stage_q[KW-1:0];
            bidx      = ~cnt_q[6:0];
        end
    end

    assign fend    = cs_q & ~cs;
    assign cnt_inc = (cnt_q == SAT_C) ? cnt_q : cnt_q + 9'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        msg_d   = msg_q;
        key_d   = key_q;
        snd_d   = snd_q;
        ready_d = ready_q;
        mosi_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (cs) begin
                    if (LSB_FIRST) stage_d = {miso, stage_q[L-1:1]};
                    else           stage_d = {stage_q[L-2:0], miso};
                    cnt_d = cnt_inc;
                end else if (fend) begin
                    cnt_d = '0;
                    if (cnt_q == L_C) begin
                        msg_d   = stage_msg;
                        key_d   = stage_key;
                        ready_d = 1'b1;
                        state_d = WAIT_CORE;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            WAIT_CORE: begin
                cnt_d = '0;
                if (finished) begin
                    ready_d = 1'b0;
                    snd_d   = parallelprocessedin;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cs) begin
                    if (cnt_q < S_C) mosi_d = snd_q[bidx];
                    cnt_d = cnt_inc;
                end else if (fend) begin
                    cnt_d = '0;
                    if (cnt_q == S_C) state_d = LOAD;
                    else              ferr_d  = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            stage_q <= '0;
            msg_q   <= '0;
            key_q   <= '0;
            snd_q   <= '0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            msg_q   <= msg_d;
            key_q   <= key_d;
            snd_q   <= snd_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    assign parallelmessageout = msg_q;
    assign parallelkeyout     = key_q;
    assign mosi               = mosi_q;
    assign ready              = ready_q;
    assign frame_err          = ferr_q;
    assign busy               = (state_q != LOAD);

endmodule

// File: tb/tb_spi_aes_frame_port.sv
// Directed bench for spi_aes_frame_port: NK=4 LSB-first and NK=8 MSB-first
// instances, with a queue of expected mosi bits for the send frames.
module tb_spi_aes_frame_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           cs_a = 0, miso_a = 0, fin_a = 0;
    logic [127:0]   pin_a = '0;
    logic [127:0]   msg_a, key_a;
    logic           mosi_a, rdy_a, fe_a, busy_a;

    logic           cs_b = 0, miso_b = 0, fin_b = 0;
    logic [127:0]   pin_b = '0;
    logic [127:0]   msg_b;
    logic [255:0]   key_b;
    logic           mosi_b, rdy_b, fe_b, busy_b;

    spi_aes_frame_port #(.NK(4), .LSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .cs(cs_a), .miso(miso_a),
        .parallelprocessedin(pin_a), .finished(fin_a),
        .parallelmessageout(msg_a), .parallelkeyout(key_a),
        .mosi(mosi_a), .ready(rdy_a), .frame_err(fe_a), .busy(busy_a)
    );

    spi_aes_frame_port #(.NK(8), .LSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .cs(cs_b), .miso(miso_b),
        .parallelprocessedin(pin_b), .finished(fin_b),
        .parallelmessageout(msg_b), .parallelkeyout(key_b),
        .mosi(mosi_b), .ready(rdy_b), .frame_err(fe_b), .busy(busy_b)
    );

    int nerr = 0;
    int nchk = 0;
    int nfe_a = 0;
    logic sb[$];

    always @(negedge clk) if (fe_a === 1'b1) nfe_a++;

    task automatic chk(input string tag, input logic [383:0] obs,
                       input logic [383:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic [383:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (b) begin cs_b = 1; miso_b = bits[i]; end
            else   begin cs_a = 1; miso_a = bits[i]; end
            @(posedge clk); #1;
        end
    endtask

    task automatic end_frame(input bit b);
        @(negedge clk);
        if (b) begin cs_b = 0; miso_b = 0; end
        else   begin cs_a = 0; miso_a = 0; end
        @(posedge clk); #1;
    endtask

    task automatic send(input bit b, input logic [127:0] res, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (b) begin cs_b = 1; sb.push_back(res[127-i]); end
            else   begin cs_a = 1; sb.push_back(res[i]); end
            @(posedge clk); #1;
            e = sb.pop_front();
            if (b) chk($sformatf("mosi_b[%0d]", i), mosi_b, e);
            else   chk($sformatf("mosi_a[%0d]", i), mosi_a, e);
        end
    endtask

    task automatic pulse_fin(input bit b, input logic [127:0] res);
        @(negedge clk);
        if (b) begin pin_b = res; fin_b = 1; end
        else   begin pin_a = res; fin_a = 1; end
        @(posedge clk); #1;
        if (b) chk("ready_b_drop", rdy_b, 0);
        else   chk("ready_a_drop", rdy_a, 0);
        @(negedge clk);
        fin_a = 0;
        fin_b = 0;
    endtask

    logic [127:0] MSG, KEY, RES, MSG2, KEY2, MSGB, RESB;
    logic [255:0] KEYB;
    logic [383:0] va, va2, vb, ones;
    int           base;

    initial begin
        MSG  = 128'h00112233445566778899AABBCCDDEEFF;
        KEY  = 128'h000102030405060708090A0B0C0D0E0F;
        RES  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        MSG2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
        KEY2 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
        MSGB = 128'hA5A55A5A0F0FF0F01234567887654321;
        KEYB = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
        RESB = 128'hF3EED1BDB5D2A03C064B5A7E3DB181F8;
        va   = {128'h0, KEY, MSG};
        va2  = {128'h0, KEY2, MSG2};
        ones = '1;
        for (int i = 0; i < 128; i++) vb[i] = MSGB[127-i];
        for (int i = 0; i < 256; i++) vb[128+i] = KEYB[255-i];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_msg", msg_a, 0);
        chk("rst_key", key_a, 0);
        chk("rst_ready", rdy_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_ferr", fe_a, 0);
        chk("rst_key_b", key_b, 0);
        @(negedge clk);
        rst = 0;

        // short load frame
        base = nfe_a;
        drive(0, va, 255);
        end_frame(0);
        chk("short_ferr", fe_a, 1);
        chk("short_ready", rdy_a, 0);
        @(posedge clk); #1;
        chk("short_ferr_once", nfe_a, base + 1);
        chk("short_ferr_low", fe_a, 0);
        chk("short_msg", msg_a, 0);

        // long load frame
        drive(0, va, 300);
        end_frame(0);
        chk("long_ferr", fe_a, 1);
        @(posedge clk); #1;
        chk("long_ferr_once", nfe_a, base + 2);
        chk("long_msg", msg_a, 0);
        chk("long_key", key_a, 0);
        chk("long_busy", busy_a, 0);

        // finished while in LOAD has no effect
        pulse_fin(0, RES);
        chk("fin_load_busy", busy_a, 0);

        // valid load
        drive(0, va, 256);
        chk("load_ready_pre", rdy_a, 0);
        end_frame(0);
        chk("load_ready", rdy_a, 1);
        chk("load_busy", busy_a, 1);
        chk("load_ferr", fe_a, 0);
        chk("load_msg", msg_a, MSG);
        chk("load_key", key_a, KEY);

        // cs in WAIT_CORE is ignored
        base = nfe_a;
        drive(0, ones, 5);
        chk("wait_mosi", mosi_a, 0);
        end_frame(0);
        @(posedge clk); #1;
        chk("wait_noferr", nfe_a, base);
        chk("wait_ready", rdy_a, 1);

        pulse_fin(0, RES);
        chk("send_busy", busy_a, 1);

        // aborted send frame, then a full one
        send(0, RES, 40);
        end_frame(0);
        chk("abort_ferr", fe_a, 1);
        chk("abort_busy", busy_a, 1);
        @(posedge clk); #1;
        chk("abort_ferr_once", nfe_a, base + 1);
        send(0, RES, 128);
        end_frame(0);
        chk("send_ferr", fe_a, 0);
        chk("send_done_busy", busy_a, 0);
        chk("send_done_mosi", mosi_a, 0);

        // NK=8, MSB first
        drive(1, vb, 384);
        end_frame(1);
        chk("b_ready", rdy_b, 1);
        chk("b_msg", msg_b, MSGB);
        chk("b_key", key_b, KEYB);
        chk("b_key255", key_b[255], vb[128]);
        pulse_fin(1, RESB);
        send(1, RESB, 128);
        end_frame(1);
        chk("b_ferr", fe_b, 0);
        chk("b_busy", busy_b, 0);

        // reset in the middle of a load frame
        drive(0, va2, 100);
        @(negedge clk);
        rst  = 1;
        cs_a = 0;
        @(posedge clk); #1;
        chk("mrst_msg", msg_a, 0);
        chk("mrst_key", key_a, 0);
        chk("mrst_ready", rdy_a, 0);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_key_b", key_b, 0);
        @(negedge clk);
        rst = 0;
        drive(0, va2, 256);
        end_frame(0);
        chk("reload_ready", rdy_a, 1);
        chk("reload_msg", msg_a, MSG2);
        chk("reload_key", key_a, KEY2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
